// File: rtl/dk_raster_gen.sv
// rtl/dk_raster_gen.sv - 256x224 raster timing, fetch coordinates and colour re-alignment for the frame doubler
module dk_raster_gen #(
    parameter int CLK_DIV     = 4,
    parameter int H_ACTIVE    = 256,
    parameter int H_TOTAL     = 384,
    parameter int HSYNC_START = 288,
    parameter int HSYNC_LEN   = 32,
    parameter int V_ACTIVE    = 224,
    parameter int V_TOTAL     = 264,
    parameter int VSYNC_START = 240,
    parameter int VSYNC_LEN   = 8,
    parameter int PIPE_LAT    = 2
) (
    input  logic       masterclk,
    input  logic       rst,
    output logic       pix_ce,
    output logic [7:0] fetch_x,
    output logic [7:0] fetch_y,
    output logic       fetch_valid,
    input  logic [7:0] color_in,
    output logic       out_pixclk,
    output logic       out_valid,
    output logic [2:0] out_r,
    output logic [2:0] out_g,
    output logic [1:0] out_b,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       frame_start
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic [8:0]       hcount;
    logic [8:0]       vcount;
    logic             active;
    logic             hsync;
    logic             vsync;
    logic             line0_first;
    logic [3:0]       pipe [PIPE_LAT];
    logic [3:0]       tail;

    // pix_ce and out_pixclk both look at the current div, so the clock level
    // rises on exactly the edge that loads new output data.
    always_ff @(posedge masterclk) begin
        if (rst) begin
            div        <= '0;
            pix_ce     <= 1'b0;
            out_pixclk <= 1'b0;
        end else begin
            div        <= (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + DIV_W'(1);
            pix_ce     <= (div == DIV_W'(CLK_DIV - 1));
            out_pixclk <= (div < DIV_W'(CLK_DIV / 2));
        end
    end

    always_ff @(posedge masterclk) begin
        if (rst) begin
            hcount <= '0;
            vcount <= 9'(V_ACTIVE);
        end else if (pix_ce) begin
            if (hcount == 9'(H_TOTAL - 1)) begin
                hcount <= '0;
                vcount <= (vcount == 9'(V_TOTAL - 1)) ? '0 : vcount + 9'd1;
            end else begin
                hcount <= hcount + 9'd1;
            end
        end
    end

    always_comb begin
        active      = (hcount < 9'(H_ACTIVE)) && (vcount < 9'(V_ACTIVE));
        hsync       = (hcount >= 9'(HSYNC_START)) && (hcount < 9'(HSYNC_START + HSYNC_LEN));
        vsync       = (vcount >= 9'(VSYNC_START)) && (vcount < 9'(VSYNC_START + VSYNC_LEN));
        line0_first = (hcount == 9'd0) && (vcount == 9'd0);
        tail        = pipe[PIPE_LAT-1];
    end

    always_ff @(posedge masterclk) begin
        if (rst) begin
            fetch_x     <= '0;
            fetch_y     <= '0;
            fetch_valid <= 1'b0;
        end else if (pix_ce) begin
            fetch_x     <= active ? hcount[7:0] : 8'd0;
            fetch_y     <= active ? vcount[7:0] : 8'd0;
            fetch_valid <= active;
        end
    end

    // Control bits travel alongside the renderer so they meet its colour.
    always_ff @(posedge masterclk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else if (pix_ce) begin
            pipe[0] <= {active, hsync, vsync, line0_first};
            for (int i = 1; i < PIPE_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge masterclk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_r       <= '0;
            out_g       <= '0;
            out_b       <= '0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            frame_start <= 1'b0;
        end else if (pix_ce) begin
            out_valid   <= tail[3];
            out_r       <= tail[3] ? color_in[2:0] : 3'd0;
            out_g       <= tail[3] ? color_in[5:3] : 3'd0;
            out_b       <= tail[3] ? color_in[7:6] : 2'd0;
            hsync_n     <= ~tail[2];
            vsync_n     <= ~tail[1];
            frame_start <= tail[0];
        end
    end

endmodule

// File: tb/tb_dk_raster_gen.sv
// tb/tb_dk_raster_gen.sv - self-checking bench for dk_raster_gen on a reduced raster
module tb_dk_raster_gen;

    localparam int HA = 16, HT = 24, HSS = 18, HSL = 3;
    localparam int VA = 6, VT = 10, VSS = 7, VSL = 2;
    localparam int CD = 4, PL = 2, CD2 = 2, PL2 = 3;
    localparam int FRAME = HT * VT;
    localparam int BLANK = (VT - VA) * HT;

    logic       masterclk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] color_in = 8'd0;
    logic [7:0] pend = 8'd0;

    logic       pix_ce_a, fetch_valid_a, out_pixclk_a, out_valid_a, hsync_n_a, vsync_n_a, frame_start_a;
    logic [7:0] fetch_x_a, fetch_y_a;
    logic [2:0] out_r_a, out_g_a;
    logic [1:0] out_b_a;
    logic       pix_ce_b, fetch_valid_b, out_pixclk_b, out_valid_b, hsync_n_b, vsync_n_b, frame_start_b;
    logic [7:0] fetch_x_b, fetch_y_b;
    logic [2:0] out_r_b, out_g_b;
    logic [1:0] out_b_b;

    dk_raster_gen #(.CLK_DIV(CD), .H_ACTIVE(HA), .H_TOTAL(HT), .HSYNC_START(HSS), .HSYNC_LEN(HSL),
                    .V_ACTIVE(VA), .V_TOTAL(VT), .VSYNC_START(VSS), .VSYNC_LEN(VSL), .PIPE_LAT(PL)) dut_a (
        .masterclk(masterclk), .rst(rst), .pix_ce(pix_ce_a), .fetch_x(fetch_x_a), .fetch_y(fetch_y_a),
        .fetch_valid(fetch_valid_a), .color_in(color_in), .out_pixclk(out_pixclk_a), .out_valid(out_valid_a),
        .out_r(out_r_a), .out_g(out_g_a), .out_b(out_b_a), .hsync_n(hsync_n_a), .vsync_n(vsync_n_a),
        .frame_start(frame_start_a));

    dk_raster_gen #(.CLK_DIV(CD2), .H_ACTIVE(HA), .H_TOTAL(HT), .HSYNC_START(HSS), .HSYNC_LEN(HSL),
                    .V_ACTIVE(VA), .V_TOTAL(VT), .VSYNC_START(VSS), .VSYNC_LEN(VSL), .PIPE_LAT(PL2)) dut_b (
        .masterclk(masterclk), .rst(rst), .pix_ce(pix_ce_b), .fetch_x(fetch_x_b), .fetch_y(fetch_y_b),
        .fetch_valid(fetch_valid_b), .color_in(8'h00), .out_pixclk(out_pixclk_b), .out_valid(out_valid_b),
        .out_r(out_r_b), .out_g(out_g_b), .out_b(out_b_b), .hsync_n(hsync_n_b), .vsync_n(vsync_n_b),
        .frame_start(frame_start_b));

    always #5 masterclk = ~masterclk;

    int tests_run = 0;
    int tests_failed = 0;
    int timeouts = 0;

    task automatic check(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Renderer model: colour for the fetch of strobe N is presented for strobe N+2.
    initial begin
        forever begin
            @(negedge masterclk);
            if (pix_ce_a) begin
                color_in = pend;
                pend = 8'(fetch_x_a + {5'd0, fetch_y_a[2:0]});
            end
        end
    end

    logic [7:0] sb_q[$];
    logic [7:0] exp_c;
    int  strobe_a = 0, last_fs = -1, frames_seen = 0, rec_pos = -1;
    bit  rec_done = 0;
    bit  rec_valid [FRAME], rec_hs [FRAME], rec_vs [FRAME], rec_fs [FRAME];
    int  wr_a = 0, wr_b = 0, fr_checks_a = 0, fr_checks_b = 0;
    bit  started_a = 0, started_b = 0, arm_a = 0, arm_b = 0;
    logic pc_prev_a = 1'b0, pc_prev_b = 1'b0, fs_prev_a = 1'b0, fs_prev_b = 1'b0;
    int  hi_a = 0, hi_b = 0, cyc_a = 0, cyc_b = 0, clk_bad_a = 0, clk_bad_b = 0;

    always @(negedge masterclk) begin
        if (rst) begin
            sb_q.delete();
            last_fs = -1; frames_seen = 0; strobe_a = 0;
            started_a = 0; started_b = 0; arm_a = 0; arm_b = 0;
            hi_a = 0; hi_b = 0; cyc_a = 0; cyc_b = 0;
            pc_prev_a = 1'b0; pc_prev_b = 1'b0; fs_prev_a = 1'b0; fs_prev_b = 1'b0;
        end else begin
            // doubler model: one write per rising pixel clock with valid high
            if (frame_start_a && !fs_prev_a) begin
                if (started_a) begin check("writes_per_frame_div4", wr_a, HA * VA); fr_checks_a++; end
                started_a = 1; wr_a = 0;
            end
            if (out_pixclk_a && !pc_prev_a && out_valid_a) wr_a++;
            if (frame_start_b && !fs_prev_b) begin
                if (started_b) begin check("writes_per_frame_div2", wr_b, HA * VA); fr_checks_b++; end
                started_b = 1; wr_b = 0;
            end
            if (out_pixclk_b && !pc_prev_b && out_valid_b) wr_b++;
            pc_prev_a = out_pixclk_a; pc_prev_b = out_pixclk_b;
            fs_prev_a = frame_start_a; fs_prev_b = frame_start_b;

            hi_a += int'(out_pixclk_a); cyc_a++;
            if (pix_ce_a) begin
                if (arm_a && (hi_a != CD / 2 || cyc_a != CD)) clk_bad_a++;
                arm_a = 1; hi_a = 0; cyc_a = 0;
            end
            hi_b += int'(out_pixclk_b); cyc_b++;
            if (pix_ce_b) begin
                if (arm_b && (hi_b != CD2 / 2 || cyc_b != CD2)) clk_bad_b++;
                arm_b = 1; hi_b = 0; cyc_b = 0;
            end

            if (pix_ce_a) begin
                strobe_a++;
                if (out_valid_a) begin
                    if (sb_q.size() == 0) begin
                        check("scoreboard_underflow", 1, 0);
                    end else begin
                        exp_c = sb_q.pop_front();
                        check("out_color", int'({out_b_a, out_g_a, out_r_a}), int'(exp_c));
                    end
                end
                if (fetch_valid_a) sb_q.push_back(8'(fetch_x_a + {5'd0, fetch_y_a[2:0]}));
                if (frame_start_a) begin
                    if (last_fs >= 0) check("frame_start_spacing", strobe_a - last_fs, FRAME);
                    last_fs = strobe_a;
                    frames_seen++;
                    if (!rec_done && rec_pos < 0) rec_pos = 0;
                end
                if (!rec_done && rec_pos >= 0) begin
                    rec_valid[rec_pos] = out_valid_a;
                    rec_hs[rec_pos] = hsync_n_a;
                    rec_vs[rec_pos] = vsync_n_a;
                    rec_fs[rec_pos] = frame_start_a;
                    rec_pos++;
                    if (rec_pos == FRAME) rec_done = 1;
                end
            end
        end
    end

    task automatic next_strobe();
        int g = 0;
        while (!pix_ce_a && g < 4 * CD) begin
            @(posedge masterclk); #1;
            g++;
        end
        if (g >= 4 * CD) timeouts++;
        @(posedge masterclk); #1;
    endtask

    task automatic run_from_reset(input string tag);
        int first_valid = -1, first_fs = -1, early_valid = 0;
        for (int s = 1; s <= BLANK + PL + 4; s++) begin
            next_strobe();
            if (fetch_valid_a && first_valid < 0) begin
                first_valid = s;
                check({tag, "_first_fetch_xy"}, int'({fetch_x_a, fetch_y_a}), 0);
            end
            if (frame_start_a && first_fs < 0) first_fs = s;
            if (out_valid_a && first_fs < 0) early_valid++;
        end
        check({tag, "_first_fetch_valid_strobe"}, first_valid, BLANK + 1);
        check({tag, "_first_frame_start_strobe"}, first_fs, BLANK + PL + 1);
        check({tag, "_out_valid_before_frame"}, early_valid, 0);
    endtask

    typedef struct {
        int h; int v;
        bit valid; bit hs_n; bit vs_n; bit fs;
    } vec_t;
    vec_t tbl [16];

    initial begin
        int n, g, p, bad, h, v;
        tbl[0]  = '{0, 0, 1, 1, 1, 1};   tbl[1]  = '{15, 0, 1, 1, 1, 0};
        tbl[2]  = '{16, 0, 0, 1, 1, 0};  tbl[3]  = '{23, 0, 0, 1, 1, 0};
        tbl[4]  = '{17, 1, 0, 1, 1, 0};  tbl[5]  = '{18, 1, 0, 0, 1, 0};
        tbl[6]  = '{20, 1, 0, 0, 1, 0};  tbl[7]  = '{21, 1, 0, 1, 1, 0};
        tbl[8]  = '{0, 5, 1, 1, 1, 0};   tbl[9]  = '{15, 5, 1, 1, 1, 0};
        tbl[10] = '{0, 6, 0, 1, 1, 0};   tbl[11] = '{5, 6, 0, 1, 1, 0};
        tbl[12] = '{5, 7, 0, 1, 0, 0};   tbl[13] = '{19, 8, 0, 0, 0, 0};
        tbl[14] = '{23, 8, 0, 1, 0, 0};  tbl[15] = '{0, 9, 0, 1, 1, 0};

        rst = 1'b1;
        repeat (5) @(posedge masterclk);
        #1;
        check("rst_pix_ce", int'(pix_ce_a), 0);
        check("rst_out_pixclk", int'(out_pixclk_a), 0);
        check("rst_valids", int'({out_valid_a, fetch_valid_a}), 0);
        check("rst_fetch_xy", int'({fetch_x_a, fetch_y_a}), 0);
        check("rst_rgb", int'({out_b_a, out_g_a, out_r_a}), 0);
        check("rst_syncs_fs", int'({hsync_n_a, vsync_n_a, frame_start_a}), 3'b110);

        @(posedge masterclk); #2 rst = 1'b0;
        n = 0;
        do begin
            @(posedge masterclk); #1;
            n++;
        end while (!pix_ce_a && n < 20);
        check("first_pix_ce_cycle", n, CD);

        run_from_reset("boot");

        g = 0;
        while (frames_seen < 3 && g < 5 * FRAME * CD) begin
            @(posedge masterclk);
            g++;
        end
        check("frames_seen_timeout", int'(frames_seen >= 3), 1);
        check("frame_recorded", int'(rec_done), 1);

        for (int i = 0; i < 16; i++) begin
            p = tbl[i].v * HT + tbl[i].h;
            check($sformatf("tbl%0d_valid", i), int'(rec_valid[p]), int'(tbl[i].valid));
            check($sformatf("tbl%0d_hsync_n", i), int'(rec_hs[p]), int'(tbl[i].hs_n));
            check($sformatf("tbl%0d_vsync_n", i), int'(rec_vs[p]), int'(tbl[i].vs_n));
            check($sformatf("tbl%0d_frame_start", i), int'(rec_fs[p]), int'(tbl[i].fs));
        end

        bad = 0;
        for (int q = 0; q < FRAME; q++) begin
            h = q % HT; v = q / HT;
            if (rec_valid[q] != (h < HA && v < VA)) bad++;
            if (rec_hs[q] != !(h >= HSS && h < HSS + HSL)) bad++;
            if (rec_vs[q] != !(v >= VSS && v < VSS + VSL)) bad++;
            if (rec_fs[q] != (h == 0 && v == 0)) bad++;
        end
        check("frame_model_mismatches", bad, 0);
        check("write_frames_div4", int'(fr_checks_a >= 2), 1);
        check("write_frames_div2", int'(fr_checks_b >= 2), 1);
        check("pixclk_shape_div4", clk_bad_a, 0);
        check("pixclk_shape_div2", clk_bad_b, 0);

        g = 0;
        while (!(fetch_valid_a && fetch_x_a == 8'd10 && fetch_y_a == 8'd3) && g < 2 * FRAME * CD) begin
            @(posedge masterclk); #1;
            g++;
        end
        check("mid_reset_point_found", int'(g < 2 * FRAME * CD), 1);
        @(posedge masterclk); #2 rst = 1'b1;
        @(posedge masterclk); #2 rst = 1'b0;
        run_from_reset("mid");

        check("strobe_timeouts", timeouts, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
